// File: rtl/mpsoc_apb_pkg.sv
// rtl/mpsoc_apb_pkg.sv - shared types and constants for the APB initiator
package mpsoc_apb_pkg;

  // Transfer sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // APB bus phases encoded as {PSEL, PENABLE}
  localparam logic [1:0] APB_PHASE_IDLE   = 2'b00;
  localparam logic [1:0] APB_PHASE_SETUP  = 2'b10;
  localparam logic [1:0] APB_PHASE_ACCESS = 2'b11;

  // Number of byte lanes for a given data width
  function automatic int strb_width(input int data_size);
    return data_size / 8;
  endfunction

endpackage

// File: rtl/mpsoc_apb_master.sv
// rtl/mpsoc_apb_master.sv - valid/ready request to APB-Lite initiator with timeout
module mpsoc_apb_master
  import mpsoc_apb_pkg::*;
#(
  parameter int PADDR_SIZE = 64,
  parameter int PDATA_SIZE = 64,
  parameter int TIMEOUT    = 255
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [PADDR_SIZE-1:0]             req_addr,
  input  logic [PDATA_SIZE-1:0]             req_wdata,
  input  logic [strb_width(PDATA_SIZE)-1:0] req_strb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [PDATA_SIZE-1:0]             rsp_rdata,
  output logic                              rsp_err,
  output logic                              PSEL,
  output logic                              PENABLE,
  output logic                              PWRITE,
  output logic [PADDR_SIZE-1:0]             PADDR,
  output logic [PDATA_SIZE-1:0]             PWDATA,
  output logic [strb_width(PDATA_SIZE)-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]             PRDATA,
  input  logic                              PREADY,
  input  logic                              PSLVERR
);

  // A zero TIMEOUT disables the abort; keep the counter at least one bit wide
  localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  apb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;

  assign req_ready = (state == IDLE);

  // Transfer FSM with registered APB and response outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      {PSEL, PENABLE} <= APB_PHASE_IDLE;
      PWRITE          <= 1'b0;
      PADDR           <= '0;
      PWDATA          <= '0;
      PSTRB           <= '0;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            PWRITE          <= req_write;
            PADDR           <= req_addr;
            PWDATA          <= req_write ? req_wdata : '0;
            PSTRB           <= req_write ? req_strb : '0;
            {PSEL, PENABLE} <= APB_PHASE_SETUP;
            state           <= SETUP;
          end
        end
        SETUP: begin
          {PSEL, PENABLE} <= APB_PHASE_ACCESS;
          wait_cnt        <= '0;
          state           <= ACCESS;
        end
        ACCESS: begin
          // PREADY wins over the timeout in the limit cycle
          if (PREADY) begin
            rsp_rdata       <= PWRITE ? '0 : PRDATA;
            rsp_err         <= PSLVERR;
            rsp_valid       <= 1'b1;
            {PSEL, PENABLE} <= APB_PHASE_IDLE;
            state           <= RESP;
          end else if ((TIMEOUT != 0) && (wait_cnt == TO_LIMIT)) begin
            rsp_rdata       <= '0;
            rsp_err         <= 1'b1;
            rsp_valid       <= 1'b1;
            {PSEL, PENABLE} <= APB_PHASE_IDLE;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_apb_master.sv
// tb/tb_mpsoc_apb_master.sv - self-checking bench for mpsoc_apb_master
module tb_mpsoc_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_strb;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA;
  logic          PREADY, PSLVERR;

  int checks   = 0;
  int failures = 0;

  mpsoc_apb_master #(.PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // One complete transfer. waits = PREADY-low ACCESS cycles offered by the slave,
  // hold = cycles rsp_ready is held low once the response appears.
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input int waits, input logic [DW-1:0] rd,
                      input logic se, input int hold);
    int            lat;
    logic          abort;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic [DW-1:0] held_rdata;
    logic          held_err;
    // Reference: response appears 3 cycles after accept plus wait cycles, capped by the timeout
    abort     = (waits > TO);
    lat       = 3 + ((waits < TO) ? waits : TO);
    exp_rdata = (abort || wr) ? '0 : rd;
    exp_err   = abort ? 1'b1 : se;

    @(negedge PCLK);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready actual=%b expected=1", req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = st;
    PREADY = 1'b0;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_strb = SW'($urandom);

    for (int k = 1; k <= lat; k++) begin
      @(negedge PCLK);
      if (k < lat) begin
        checks++;
        if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, req_ready} !==
            {1'b1, (k >= 2), wr, a, (wr ? wd : {DW{1'b0}}), (wr ? st : {SW{1'b0}}), 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL apb_cycle%0d actual sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h rv=%b rr=%b expected sel=1 en=%b wr=%b addr=%h wdata=%h strb=%h rv=0 rr=0",
                   k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, req_ready,
                   (k >= 2), wr, a, (wr ? wd : {DW{1'b0}}), (wr ? st : {SW{1'b0}}));
        end
        PSLVERR = $urandom_range(0, 1);
        PRDATA  = $urandom;
        PREADY  = 1'b0;
        if (k >= 2 && (k - 2) == waits) begin
          PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
        end
      end else begin
        PREADY = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, req_ready} !==
            {1'b1, exp_err, exp_rdata, 1'b0, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL response actual rv=%b err=%b rdata=%h sel=%b en=%b rr=%b expected rv=1 err=%b rdata=%h sel=0 en=0 rr=0",
                   rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE, req_ready, exp_err, exp_rdata);
        end
      end
    end

    held_rdata = rsp_rdata;
    held_err   = rsp_err;
    // Offer a new request during backpressure; it must not be taken
    req_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready, PSEL} !== {1'b1, exp_rdata, exp_err, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL backpressure%0d actual rv=%b rdata=%h err=%b rr=%b sel=%b expected rv=1 rdata=%h err=%b rr=0 sel=0",
                 h, rsp_valid, rsp_rdata, rsp_err, req_ready, PSEL, held_rdata, held_err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 rsp_ready = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, req_ready, PSEL} !== 3'b010) begin
      failures++;
      $display("FAIL after_rsp actual rv=%b rr=%b sel=%b expected rv=0 rr=1 sel=0", rsp_valid, req_ready, PSEL);
    end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
    rsp_ready = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, req_ready} !==
        {3'b000, {AW{1'b0}}, {DW{1'b0}}, {SW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values actual sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h rv=%b rdata=%h err=%b rr=%b expected all 0 rr=1",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    PRESETn = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    xfer(1'b1, 32'h2, 32'hA5, 4'h1, 0, 32'hDEAD_BEEF, 1'b0, 0);
  endtask

  task automatic test_read_waits();
    xfer(1'b0, 32'h40, 32'hFFFF_FFFF, 4'hF, 3, 32'h1234, 1'b0, 0);
  endtask

  task automatic test_slave_error();
    xfer(1'b0, 32'h80, 32'h0, 4'h0, 0, 32'h55AA, 1'b1, 3);
    xfer(1'b1, 32'h84, 32'h77, 4'hC, 1, 32'h0, 1'b1, 0);
  endtask

  task automatic test_timeout();
    xfer(1'b0, 32'hC0, 32'h0, 4'h0, 20, 32'h9999, 1'b0, 0);
    xfer(1'b0, 32'hC4, 32'h0, 4'h0, TO, 32'h4321, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    xfer(1'b0, 32'h100, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b0, 10);
  endtask

  task automatic test_reset_in_access();
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h1111; req_strb = 4'hF;
    PREADY = 1'b0;
    @(posedge PCLK);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err, req_ready} !==
        {3'b000, {AW{1'b0}}, {DW{1'b0}}, {SW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset actual sel=%b en=%b wr=%b addr=%h wdata=%h strb=%h rv=%b err=%b rr=%b expected all 0 rr=1",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_err, req_ready);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge PCLK);
      checks++;
      if ({rsp_valid, PSEL, req_ready} !== 3'b001) begin
        failures++;
        $display("FAIL post_reset%0d actual rv=%b sel=%b rr=%b expected rv=0 sel=0 rr=1", c, rsp_valid, PSEL, req_ready);
      end
    end
    PREADY = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, SW'($urandom),
           int'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_reset_in_access();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
